// File: rtl/systolic_pkg.sv
// Shared types for the systolic array edge logic: collector FSM states,
// result element type and the counter-width helper.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } collector_state_t;

    localparam int ELEM_SIZE = 32;

    typedef logic [ELEM_SIZE-1:0] elem_t;

    // A counter that must be able to hold the value n (not just n-1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Row-stream handshake between the result collector and its downstream consumer.
interface result_collector_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) ();

    logic                              out_valid;
    logic                              out_ready;
    logic [MATRIX_SIZE*DATA_SIZE-1:0]  out_data;
    logic                              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/result_collector_col_buffer.sv
// One column of the de-skew buffer: stores up to MATRIX_SIZE results in
// arrival order and flags writes that arrive after the column is full.
module col_buffer
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [DATA_SIZE-1:0]             wr_data,
    output logic [MATRIX_SIZE*DATA_SIZE-1:0] entries,
    output logic                             fills,
    output logic                             overflow_hit
);

    localparam int              CNT_W = cnt_width(MATRIX_SIZE);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MATRIX_SIZE);

    logic [CNT_W-1:0]     cnt;
    logic [DATA_SIZE-1:0] mem [MATRIX_SIZE];
    logic                 full;
    logic                 accept;

    assign full         = (cnt == DEPTH);
    assign accept       = wr_en && !full;
    assign overflow_hit = wr_en && full;
    // Full now, or becomes full with this cycle's write.
    assign fills        = full || (accept && (cnt == DEPTH - 1'b1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Data storage carries no reset; contents are only read after a full collect.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            if (accept && (cnt == CNT_W'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        entries = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            entries[i*DATA_SIZE +: DATA_SIZE] = mem[i];
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects skewed column results from the systolic array, de-skews them and
// streams the matrix out row by row. Optional watchdog: COLLECT_TIMEOUT_EN.
module result_collector
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE    = 2,
    parameter int DATA_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [MATRIX_SIZE-1:0]           col_valid,
    input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
    result_collector_if.master               rows,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic                             timeout
);

    localparam int               ROW_W    = MATRIX_SIZE * DATA_SIZE;
    localparam int               CNT_W    = cnt_width(MATRIX_SIZE);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MATRIX_SIZE - 1);

    collector_state_t        state;
    logic [CNT_W-1:0]        row_ptr;
    logic [CNT_W-1:0]        next_row;
    logic                    row_valid;
    logic                    row_last;
    logic                    clear;
    logic [MATRIX_SIZE-1:0]  wr_en;
    logic [MATRIX_SIZE-1:0]  col_fills;
    logic [MATRIX_SIZE-1:0]  col_ovf;
    logic [ROW_W-1:0]        col_entries [MATRIX_SIZE];
    logic [ROW_W-1:0]        row_data;
    logic                    all_full;
    logic                    any_ovf;

    assign clear    = (state == IDLE) && start;
    assign all_full = &col_fills;
    assign any_ovf  = |col_ovf;
    assign next_row = row_ptr + 1'b1;
    assign busy     = (state != IDLE);

    for (genvar j = 0; j < MATRIX_SIZE; j++) begin : g_col
        assign wr_en[j] = (state == COLLECT) && col_valid[j];

        col_buffer #(
            .MATRIX_SIZE (MATRIX_SIZE),
            .DATA_SIZE   (DATA_SIZE)
        ) u_col (
            .clk          (clk),
            .reset        (reset),
            .clear        (clear),
            .wr_en        (wr_en[j]),
            .wr_data      (col_data[j*DATA_SIZE +: DATA_SIZE]),
            .entries      (col_entries[j]),
            .fills        (col_fills[j]),
            .overflow_hit (col_ovf[j])
        );
    end

    // Row mux: element j of row r is entry r of column j.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            if (row_ptr == CNT_W'(r)) begin
                for (int j = 0; j < MATRIX_SIZE; j++) begin
                    row_data[j*DATA_SIZE +: DATA_SIZE] = col_entries[j][r*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    assign rows.out_valid = row_valid;
    assign rows.out_last  = row_last;
    assign rows.out_data  = row_valid ? row_data : '0;

`ifdef COLLECT_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdog;
    logic            wdog_expire;
    logic            timeout_flag;

    // Expires on the TIMEOUT_CYCLES-th cycle spent in COLLECT.
    assign wdog_expire = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout     = timeout_flag;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            row_ptr   <= '0;
            row_valid <= 1'b0;
            row_last  <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
            wdog         <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        row_ptr  <= '0;
                        overflow <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
                        wdog         <= '0;
                        timeout_flag <= 1'b0;
`endif
                    end
                end
                COLLECT: begin
                    if (any_ovf) begin
                        overflow <= 1'b1;
                    end
                    if (all_full) begin
                        state     <= DRAIN;
                        row_valid <= 1'b1;
                        row_last  <= (row_ptr == LAST_ROW);
                    end
`ifdef COLLECT_TIMEOUT_EN
                    else if (wdog_expire) begin
                        state        <= IDLE;
                        timeout_flag <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (rows.out_ready) begin
                        row_ptr <= next_row;
                        if (row_last) begin
                            state     <= IDLE;
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            row_last <= (next_row == LAST_ROW);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a queue-based reference model and
// per-cycle output comparison.
module tb_result_collector;
    import systolic_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int W  = N * DW;
    localparam int TO = 8;
`ifdef COLLECT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk       = 1'b0;
    logic         reset     = 1'b0;
    logic         start     = 1'b0;
    logic [N-1:0] col_valid = '0;
    logic [W-1:0] col_data  = '0;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         timeout;

    result_collector_if #(.MATRIX_SIZE(N), .DATA_SIZE(DW)) rows_if ();

    result_collector #(
        .MATRIX_SIZE    (N),
        .DATA_SIZE      (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_valid (col_valid),
        .col_data  (col_data),
        .rows      (rows_if),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    bit chk_en = 1'b1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-column arrival queues; a row is the r-th arrival of every column.
    int    m_phase = 0;  // 0 idle, 1 collecting, 2 draining
    elem_t m_col [N][$];
    int    m_row   = 0;
    int    m_wd    = 0;
    bit    m_done  = 1'b0;
    bit    m_ovf   = 1'b0;
    bit    m_to    = 1'b0;

    initial begin
        bit complete;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_phase = 0;
                m_row   = 0;
                m_wd    = 0;
                m_done  = 1'b0;
                m_ovf   = 1'b0;
                m_to    = 1'b0;
                for (int j = 0; j < N; j++) m_col[j].delete();
            end else begin
                m_done = 1'b0;
                case (m_phase)
                    0: if (start) begin
                        m_phase = 1;
                        m_row   = 0;
                        m_wd    = 0;
                        m_ovf   = 1'b0;
                        m_to    = 1'b0;
                        for (int j = 0; j < N; j++) m_col[j].delete();
                    end
                    1: begin
                        complete = 1'b1;
                        for (int j = 0; j < N; j++) begin
                            if (col_valid[j]) begin
                                if (m_col[j].size() < N) m_col[j].push_back(col_data[j*DW +: DW]);
                                else m_ovf = 1'b1;
                            end
                            if (m_col[j].size() != N) complete = 1'b0;
                        end
                        if (complete) begin
                            m_phase = 2;
                        end else if (TO_EN) begin
                            m_wd++;
                            if (m_wd >= TO) begin
                                m_to    = 1'b1;
                                m_phase = 0;
                            end
                        end
                    end
                    2: if (rows_if.out_ready) begin
                        m_row++;
                        if (m_row == N) begin
                            m_phase = 0;
                            m_done  = 1'b1;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    logic [W-1:0] exp_row;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      busy,              m_phase != 0);
            check("out_valid", rows_if.out_valid, m_phase == 2);
            check("out_last",  rows_if.out_last,  (m_phase == 2) && (m_row == N - 1));
            check("done",      done,              m_done);
            check("overflow",  overflow,          m_ovf);
            check("timeout",   timeout,           m_to);
            if (m_phase == 2 && m_row < N) begin
                exp_row = '0;
                for (int j = 0; j < N; j++) exp_row[j*DW +: DW] = m_col[j][m_row];
                check("out_data", rows_if.out_data, exp_row);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Skewed arrival: col0 rows on cycles 1,2; col1 rows on cycles 2,3.
    task automatic load_skew(input elem_t r0c0, input elem_t r1c0, input elem_t r0c1, input elem_t r1c1);
        col_valid = 2'b01; col_data = {32'h0, r0c0}; tick();
        col_valid = 2'b11; col_data = {r0c1, r1c0};  tick();
        col_valid = 2'b10; col_data = {r1c1, 32'h0}; tick();
        col_valid = 2'b00; col_data = '0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (done !== 1'b1 && k < bound) begin
            tick();
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_done: done not seen within %0d cycles", bound);
        end
    endtask

    initial begin
        rows_if.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_valid", rows_if.out_valid, 1'b0);
        check("rst_busy",  busy,              1'b0);
        check("rst_done",  done,              1'b0);
        check("rst_ovf",   overflow,          1'b0);
        check("rst_to",    timeout,           1'b0);
        reset = 1'b1;
        tick();

        // Basic skewed collect and drain
        do_start();
        check("t1_busy", busy, 1'b1);
        load_skew(32'h11, 32'h21, 32'h12, 32'h22);
        check("t1_valid", rows_if.out_valid, 1'b1);
        check("t1_row0",  rows_if.out_data,  64'h00000012_00000011);
        check("t1_last0", rows_if.out_last,  1'b0);
        tick();
        check("t1_row1",  rows_if.out_data,  64'h00000022_00000021);
        check("t1_last1", rows_if.out_last,  1'b1);
        tick();
        check("t1_done",  done, 1'b1);
        check("t1_idle",  busy, 1'b0);
        tick();
        check("t1_done_pulse", done, 1'b0);

        // Backpressure holds row 0
        rows_if.out_ready = 1'b0;
        do_start();
        load_skew(32'h11, 32'h21, 32'h12, 32'h22);
        repeat (5) begin
            check("t2_hold", rows_if.out_data, 64'h00000012_00000011);
            tick();
        end
        check("t2_valid", rows_if.out_valid, 1'b1);
        rows_if.out_ready = 1'b1;
        tick();
        check("t2_row1", rows_if.out_data, 64'h00000022_00000021);
        wait_done(10);

        // Overflow on a third col0 write
        do_start();
        col_valid = 2'b01; col_data = {32'h0, 32'h11};  tick();
        col_valid = 2'b01; col_data = {32'h0, 32'h21};  tick();
        col_valid = 2'b11; col_data = {32'h12, 32'h31}; tick();
        check("t3_ovf", overflow, 1'b1);
        col_valid = 2'b10; col_data = {32'h22, 32'h0};  tick();
        col_valid = 2'b00; col_data = '0;
        check("t3_row0", rows_if.out_data, 64'h00000012_00000011);
        tick();
        check("t3_row1", rows_if.out_data, 64'h00000022_00000021);
        wait_done(10);
        check("t3_ovf_sticky", overflow, 1'b1);

        // Back-to-back start in the done cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy",    busy,     1'b1);
        check("t4_ovf_clr", overflow, 1'b0);
        load_skew(32'hA00, 32'hA10, 32'hA01, 32'hA11);
        check("t4_row0", rows_if.out_data, 64'h00000A01_00000A00);
        wait_done(10);

        // Reset in the middle of the drain
        do_start();
        load_skew(32'h5A01, 32'h5A02, 32'h5A03, 32'h5A04);
        tick();
        check("t5_row1", rows_if.out_data, 64'h00005A04_00005A02);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", rows_if.out_valid, 1'b0);
        check("t5_rst_last",  rows_if.out_last,  1'b0);
        check("t5_rst_data",  rows_if.out_data,  64'h0);
        check("t5_rst_busy",  busy,              1'b0);
        tick();
        reset     = 1'b1;
        col_valid = 2'b11;
        col_data  = {32'hDEAD, 32'hBEEF};
        repeat (3) tick();
        check("t5_ignore_busy", busy,     1'b0);
        check("t5_ignore_ovf",  overflow, 1'b0);
        col_valid = 2'b00;
        col_data  = '0;
        do_start();
        load_skew(32'h1, 32'h2, 32'h3, 32'h4);
        check("t5_row0", rows_if.out_data, 64'h00000003_00000001);
        wait_done(10);

`ifdef COLLECT_TIMEOUT_EN
        // Watchdog: only col0 delivers
        do_start();
        col_valid = 2'b01; col_data = {32'h0, 32'h77}; tick();
        col_valid = 2'b01; col_data = {32'h0, 32'h78}; tick();
        col_valid = 2'b00; col_data = '0;
        repeat (5) tick();
        check("t6_not_yet", timeout, 1'b0);
        check("t6_busy",    busy,    1'b1);
        tick();
        check("t6_timeout", timeout,           1'b1);
        check("t6_idle",    busy,              1'b0);
        check("t6_novalid", rows_if.out_valid, 1'b0);
        repeat (3) tick();
        check("t6_nodone",  done,    1'b0);
        check("t6_sticky",  timeout, 1'b1);
        do_start();
        check("t6_to_clr", timeout, 1'b0);
        load_skew(32'h91, 32'h92, 32'h93, 32'h94);
        wait_done(10);
`endif

        tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
